// File: rtl/seg7_scan_display.sv
// Rebuilds a 4-digit BCD value from a time-multiplexed digit bus and scans a
// common-anode 4-digit 7-segment display with anti-ghost and leading-zero blanking.
module seg7_scan_display #(
    parameter int REFRESH_DIV  = 50,
    parameter int BLANK_CYCLES = 2,
    parameter int SEL_LAG      = 1,
    parameter int BLANK_LZ     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic [1:0] digit_sel,
    input  logic       react,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_commit
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // gfedcba, active-high; anything that is not BCD shows a dash
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    logic [3:0]    shadow_q [4];
    logic [3:0]    display_q [4];
    logic          commit_pend_q;
    logic          frame_commit_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    slot_s;
    logic          blank_s;
    logic          lz_blank_s;
    logic [3:0]    cur_digit_s;

    assign slot_s = digit_sel - 2'(SEL_LAG);

    // Shadow capture; a slot-3 capture arms the commit for the next clock
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= 4'd0;
            commit_pend_q <= 1'b0;
        end else begin
            shadow_q[slot_s] <= digit_in;
            commit_pend_q    <= (slot_s == 2'd3);
        end
    end

    // Whole-set commit: shadow[3] already holds the slot-3 digit at this point
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) display_q[i] <= 4'd0;
            frame_commit_q <= 1'b0;
        end else begin
            frame_commit_q <= commit_pend_q;
            if (commit_pend_q) begin
                for (int i = 0; i < 4; i++) display_q[i] <= shadow_q[i];
            end else begin
                for (int i = 0; i < 4; i++) display_q[i] <= display_q[i];
            end
        end
    end

    // Refresh counter and scan index next-state
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = CW'(0);
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Leading-zero test for the digit currently being scanned
    always_comb begin
        lz_blank_s = 1'b0;
        if (BLANK_LZ != 0) begin
            case (idx_q)
                2'd3:    lz_blank_s = (display_q[3] == 4'd0);
                2'd2:    lz_blank_s = (display_q[3] == 4'd0) && (display_q[2] == 4'd0);
                2'd1:    lz_blank_s = (display_q[3] == 4'd0) && (display_q[2] == 4'd0)
                                   && (display_q[1] == 4'd0);
                default: lz_blank_s = 1'b0;
            endcase
        end else begin
            lz_blank_s = 1'b0;
        end
    end

    assign blank_s     = (cnt_q < CW'(BLANK_CYCLES));
    assign cur_digit_s = display_q[idx_q];

    // Output next-state: all dark during the anti-ghost window
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (blank_s) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank_s ? 7'h7F : ~decode(cur_digit_s);
            dp_d  = ~((idx_q == 2'd0) && react);
        end
    end

    // Scan state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(0);
            idx_q <= 2'd0;
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign frame_commit = frame_commit_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display: drives a rotating digit bus
// and checks scan timing, decode, blanking, DP and atomic commit behaviour.
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic [1:0] digit_sel;
    logic       react;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_commit;

    seg7_scan_display dut (
        .clk          (clk),
        .rst          (rst),
        .digit_in     (digit_in),
        .digit_sel    (digit_sel),
        .react        (react),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .frame_commit (frame_commit)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] pat [4];
    logic [1:0] sel_r;
    logic       stall;

    int         low_cnt [4];
    logic [6:0] last_seg [4];
    int         dp_low, dp_bad, fc_cnt, order_err, illegal_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the bus 1 ns after the edge, return 4 ns after the edge
    task automatic tick;
        logic [1:0] slot_v;
        @(posedge clk);
        #1;
        if (!stall) sel_r = sel_r + 2'd1;
        slot_v    = sel_r - 2'd1;
        digit_sel = sel_r;
        digit_in  = pat[slot_v];
        #3;
    endtask

    function automatic int an_to_idx(input logic [3:0] a);
        case (a)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            4'hF:    return -1;
            default: return -2;
        endcase
    endfunction

    task automatic run_window(input int n);
        int         k;
        logic [3:0] prev_act, exp_next;
        for (int i = 0; i < 4; i++) begin
            low_cnt[i]  = 0;
            last_seg[i] = 7'h00;
        end
        dp_low = 0; dp_bad = 0; fc_cnt = 0; order_err = 0; illegal_an = 0;
        prev_act = 4'hF;
        for (int c = 0; c < n; c++) begin
            tick();
            k = an_to_idx(an);
            if (frame_commit) fc_cnt++;
            if (dp == 1'b0) begin
                dp_low++;
                if (an != 4'hE) dp_bad++;
            end
            if (k == -2) illegal_an++;
            if (k >= 0) begin
                low_cnt[k]++;
                last_seg[k] = seg;
                if (prev_act != 4'hF && an != prev_act) begin
                    exp_next = ~{~prev_act[2:0], ~prev_act[3]};
                    if (an != exp_next) order_err++;
                end
                prev_act = an;
            end
        end
    endtask

    task automatic set_pat(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
        pat[0] = d0; pat[1] = d1; pat[2] = d2; pat[3] = d3;
    endtask

    initial begin
        int         bad_an, mix_err, k;
        logic       seen_new, found, is_old, is_new;
        logic [6:0] new_seg [4];

        rst = 1'b1; react = 1'b0; stall = 1'b0; sel_r = 2'd0;
        digit_sel = 2'd0; digit_in = 4'd0;
        set_pat(4'd7, 4'd3, 4'd0, 4'd0);

        // Reset state and idle under reset
        tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fc", frame_commit, 1'b0);
        bad_an = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an != 4'hF) bad_an++;
        end
        check("rst_idle_an", bad_an, 0);

        // Release: two blank cycles, then digit 0 lights
        rst = 1'b0;
        tick();
        tick();
        check("first_blank_an", an, 4'hF);
        tick();
        check("first_active_an", an, 4'hE);

        // Stream 0037: decode, leading-zero blanking, duty cycle, order, commit rate
        run_window(10);
        run_window(200);
        check("t2_seg_an0", last_seg[0], 7'h78);
        check("t2_seg_an1", last_seg[1], 7'h30);
        check("t2_seg_an2", last_seg[2], 7'h7F);
        check("t2_seg_an3", last_seg[3], 7'h7F);
        for (int i = 0; i < 4; i++) check($sformatf("t4_low_an%0d", i), low_cnt[i], 48);
        check("t4_order", order_err, 0);
        check("t4_illegal_an", illegal_an, 0);
        check("t2_fc_rate", fc_cnt, 50);
        check("t2_dp_idle", dp_low, 0);

        // 9999 then an atomic switch to 0001 on a bus-frame boundary
        set_pat(4'd9, 4'd9, 4'd9, 4'd9);
        run_window(220);
        for (int i = 0; i < 4; i++) check($sformatf("t3_9999_an%0d", i), last_seg[i], 7'h10);
        run_window(73);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (sel_r == 2'd0) found = 1'b1;
            else tick();
        end
        check("t3_align", found, 1'b1);
        set_pat(4'd1, 4'd0, 4'd0, 4'd0);
        new_seg[0] = 7'h79; new_seg[1] = 7'h7F; new_seg[2] = 7'h7F; new_seg[3] = 7'h7F;
        seen_new = 1'b0; mix_err = 0;
        for (int c = 0; c < 220; c++) begin
            tick();
            k = an_to_idx(an);
            if (k >= 0) begin
                is_old = (seg == 7'h10);
                is_new = (seg == new_seg[k]);
                if (is_new) seen_new = 1'b1;
                if ((is_old && seen_new) || (!is_old && !is_new)) mix_err++;
            end
        end
        check("t3_no_mix", mix_err, 0);
        check("t3_switched", seen_new, 1'b1);

        // 0042 with react: DP only in the digit-0 active window
        set_pat(4'd2, 4'd4, 4'd0, 4'd0);
        react = 1'b1;
        run_window(10);
        run_window(200);
        check("t5_seg_an0", last_seg[0], 7'h24);
        check("t5_seg_an1", last_seg[1], 7'h19);
        check("t5_seg_an2", last_seg[2], 7'h7F);
        check("t5_seg_an3", last_seg[3], 7'h7F);
        check("t5_dp_low", dp_low, 48);
        check("t5_dp_outside", dp_bad, 0);
        react = 1'b0;
        run_window(1);
        run_window(200);
        check("t5_dp_off", dp_low, 0);

        // Non-BCD thousands digit shows a dash; inner zeros are no longer leading
        set_pat(4'd0, 4'd0, 4'd0, 4'hC);
        run_window(10);
        run_window(200);
        check("t6_seg_an3", last_seg[3], 7'h3F);
        check("t6_seg_an2", last_seg[2], 7'h40);
        check("t6_seg_an1", last_seg[1], 7'h40);
        check("t6_seg_an0", last_seg[0], 7'h40);

        // Reset during digit-2 slot
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (an == 4'hB) found = 1'b1;
        end
        check("t6_find_slot2", found, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_rst_an", an, 4'hF);
        check("t6_rst_seg", seg, 7'h7F);
        check("t6_rst_fc", frame_commit, 1'b0);

        // Stalled bus never reaching slot 3: display stays at the reset value 0
        stall = 1'b1;
        sel_r = 2'd1;
        tick();
        rst = 1'b0;
        run_window(10);
        run_window(200);
        check("t6_zero_an0", last_seg[0], 7'h40);
        check("t6_zero_an1", last_seg[1], 7'h7F);
        check("t6_zero_an3", last_seg[3], 7'h7F);
        check("t6_stall_fc", fc_cnt, 0);
        check("t6_stall_low_an2", low_cnt[2], 48);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
